// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg: shared types, channel indices and bit-offset helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  typedef enum logic [0:0] {
    ST_CAPTURE = 1'b0,
    ST_FLUSH   = 1'b1
  } state_e;

  localparam int c_ch_red   = 0;
  localparam int c_ch_green = 1;
  localparam int c_ch_blue  = 2;
  localparam int c_channels = c_ch_blue + 1;

  function automatic int rgb_offset(input int seg, input int ch);
    return c_channels * seg + ch;
  endfunction

  function automatic int pixel_offset(input int seg, input int ch, input int cw);
    return cw * rgb_offset(seg, ch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_count_decoder.sv
// ----------------------------------------------------------------------------
// display_count_decoder: enabled-period count to channel value (n -> n-1, sat)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module display_count_decoder #(
  parameter int CYCLEWIDTH = 8
) (
  input  logic [CYCLEWIDTH:0]   count_i,
  output logic [CYCLEWIDTH-1:0] value_o
);

  localparam logic [CYCLEWIDTH:0] c_max = {1'b0, {CYCLEWIDTH{1'b1}}};

  logic [CYCLEWIDTH:0] w_dec;

  always_comb begin
    w_dec = (count_i == '0) ? '0 : count_i - (CYCLEWIDTH + 1)'(1);
    if (w_dec > c_max) w_dec = c_max;
    value_o = w_dec[CYCLEWIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/display_receiver.sv
// ----------------------------------------------------------------------------
// display_receiver: decodes the latched row/column panel stream into frame-buffer words
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module display_receiver
  import display_pkg::*;
#(
  parameter int SEGMENTS   = 1,
  parameter int ROWS       = 8,
  parameter int COLUMNS    = 32,
  parameter int CYCLEWIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3*SEGMENTS-1:0]              rgb_in,
  input  logic                               oclk_in,
  input  logic                               lat_in,
  input  logic                               oe_in,
  input  logic [$clog2(ROWS)-1:0]            row_in,
  output logic                               wr_valid,
  input  logic                               wr_ready,
  output logic [$clog2(ROWS)-1:0]            wr_row,
  output logic [$clog2(COLUMNS)-1:0]         wr_column,
  output logic [CYCLEWIDTH*3*SEGMENTS-1:0]   wr_pixel,
  output logic                               row_complete,
  output logic                               frame_complete,
  output logic                               overrun,
  output logic                               overflow
);

  localparam int c_pix = c_channels * SEGMENTS;
  localparam int c_rw  = $clog2(ROWS);
  localparam int c_cw  = $clog2(COLUMNS);
  localparam int c_iw  = $clog2(COLUMNS + 1);
  localparam logic [CYCLEWIDTH:0] c_acc_max = (CYCLEWIDTH + 1)'(1) << CYCLEWIDTH;

  logic [c_pix-1:0]      rgb_q;
  logic                  oclk_q, oclk_p_q, lat_q, lat_p_q, oe_q, oe_p_q;
  logic [c_rw-1:0]       row_q, cur_row_q, wr_row_q;
  logic [c_iw-1:0]       col_idx_q;
  logic [c_cw-1:0]       wr_column_q;
  logic [c_pix-1:0]      slots_q [COLUMNS];
  logic [c_pix-1:0]      disp_q  [COLUMNS];
  logic [CYCLEWIDTH:0]   acc_q   [COLUMNS][c_pix];
  state_e                state_q;
  logic                  dirty_q, wr_valid_q;
  logic                  row_complete_q, frame_complete_q, overrun_q, overflow_q;

  logic w_oclk_rise, w_lat_rise, w_oe_rise;

  assign w_oclk_rise = oclk_q & ~oclk_p_q;
  assign w_lat_rise  = lat_q & ~lat_p_q;
  assign w_oe_rise   = oe_q & ~oe_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= '0;
      row_q    <= '0;
      oclk_q   <= 1'b0;
      oclk_p_q <= 1'b0;
      lat_q    <= 1'b0;
      lat_p_q  <= 1'b0;
      oe_q     <= 1'b0;
      oe_p_q   <= 1'b0;
    end else begin
      rgb_q    <= rgb_in;
      row_q    <= row_in;
      oclk_q   <= oclk_in;
      oclk_p_q <= oclk_q;
      lat_q    <= lat_in;
      lat_p_q  <= lat_q;
      oe_q     <= oe_in;
      oe_p_q   <= oe_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_CAPTURE;
      col_idx_q        <= '0;
      cur_row_q        <= '0;
      dirty_q          <= 1'b0;
      wr_valid_q       <= 1'b0;
      wr_row_q         <= '0;
      wr_column_q      <= '0;
      row_complete_q   <= 1'b0;
      frame_complete_q <= 1'b0;
      overrun_q        <= 1'b0;
      overflow_q       <= 1'b0;
      for (int c = 0; c < COLUMNS; c++) begin
        slots_q[c] <= '0;
        disp_q[c]  <= '0;
        for (int p = 0; p < c_pix; p++) acc_q[c][p] <= '0;
      end
    end else begin
      row_complete_q   <= 1'b0;
      frame_complete_q <= 1'b0;
      overrun_q        <= 1'b0;
      overflow_q       <= 1'b0;

      case (state_q)
        ST_CAPTURE: begin
          if (w_oe_rise) begin
            for (int c = 0; c < COLUMNS; c++)
              for (int p = 0; p < c_pix; p++)
                if (disp_q[c][p] && acc_q[c][p] != c_acc_max)
                  acc_q[c][p] <= acc_q[c][p] + (CYCLEWIDTH + 1)'(1);
          end
          if (row_q != cur_row_q) begin
            if (dirty_q) begin
              state_q     <= ST_FLUSH;
              wr_valid_q  <= 1'b1;
              wr_row_q    <= cur_row_q;
              wr_column_q <= '0;
            end else begin
              cur_row_q <= row_q;
            end
          end
        end
        ST_FLUSH: begin
          if (w_oe_rise) overrun_q <= 1'b1;
          if (wr_ready) begin
            for (int p = 0; p < c_pix; p++) acc_q[wr_column_q][p] <= '0;
            if (wr_column_q == c_cw'(COLUMNS - 1)) begin
              state_q          <= ST_CAPTURE;
              wr_valid_q       <= 1'b0;
              wr_column_q      <= '0;
              dirty_q          <= 1'b0;
              row_complete_q   <= 1'b1;
              frame_complete_q <= (wr_row_q == c_rw'(ROWS - 1));
            end else begin
              wr_column_q <= wr_column_q + c_cw'(1);
            end
          end
        end
        default: state_q <= ST_CAPTURE;
      endcase

      // Latch copies the old slots first, so a coincident shift lands in slot 0 of the new load.
      if (w_lat_rise) begin
        disp_q    <= slots_q;
        col_idx_q <= '0;
        dirty_q   <= 1'b1;
        cur_row_q <= row_q;
      end
      if (w_oclk_rise) begin
        if (w_lat_rise) begin
          slots_q[0] <= rgb_q;
          col_idx_q  <= c_iw'(1);
        end else if (col_idx_q == c_iw'(COLUMNS)) begin
          overflow_q <= 1'b1;
        end else begin
          slots_q[col_idx_q[c_cw-1:0]] <= rgb_q;
          col_idx_q                    <= col_idx_q + c_iw'(1);
        end
      end
    end
  end

  logic [CYCLEWIDTH:0] w_count [c_pix];

  for (genvar p = 0; p < c_pix; p++) begin : g_dec
    localparam int c_lo = pixel_offset(p / c_channels, p % c_channels, CYCLEWIDTH);
    assign w_count[p] = wr_valid_q ? acc_q[wr_column_q][p] : '0;
    display_count_decoder #(
      .CYCLEWIDTH(CYCLEWIDTH)
    ) u_dec (
      .count_i(w_count[p]),
      .value_o(wr_pixel[c_lo +: CYCLEWIDTH])
    );
  end

  assign wr_valid       = wr_valid_q;
  assign wr_row         = wr_row_q;
  assign wr_column      = wr_column_q;
  assign row_complete   = row_complete_q;
  assign frame_complete = frame_complete_q;
  assign overrun        = overrun_q;
  assign overflow       = overflow_q;

endmodule

`default_nettype wire

// File: doc/display_receiver.md
# display_receiver

Decoder for the serial latched row/column panel interface produced by `display_driver`. Samples `rgb`, `oclk`, `lat`, `oe` and `row`, then shifts in column bits and counts enabled display periods per pixel. Recovers each pixel's cycle value and writes one column word per row to a frame-buffer write port. Used for loopback self-test of the driver and as the input stage of a chained-panel repeater.

## Interface
- `segments`, 1: parallel panel segments, each carrying 3 rgb bits.
- `rows`, 8: addressable rows.
- `columns`, 32: columns per row load.
- `cyclewidth`, 8: bits per colour channel, in the corrected (post-encoder) domain.

Ports:
- `clk`, input, 1: system clock, shared with the driver.
- `rst`, input, 1: synchronous, active-high reset.
- `rgb_in`, input, 3*segments: bit 3*i+c is segment i, channel c (0=r, 1=g, 2=b).
- `oclk_in`, input, 1: column shift clock.
- `lat_in`, input, 1: latch strobe.
- `oe_in`, input, 1: output enable, active-high.
- `row_in`, input, $clog2(rows): row address.
- `wr_valid`, output, 1: write word valid.
- `wr_ready`, input, 1: write port accepts the word.
- `wr_row`, output, $clog2(rows): row of the word.
- `wr_column`, output, $clog2(columns): column of the word.
- `wr_pixel`, output, cyclewidth*3*segments: decoded value for segment i, channel c at bit offset cyclewidth*3*i + cyclewidth*c.
- `row_complete`, output, 1: one-clk pulse when a row flush finishes.
- `frame_complete`, output, 1: one-clk pulse when the flush of row rows-1 finishes.
- `overrun`, output, 1: one-clk pulse when an `oe` rise is dropped during a flush.
- `overflow`, output, 1: one-clk pulse when an `oclk` rise arrives beyond `columns`.

## Operation
- **Input stage**
  - All five inputs are registered once.
  - Rising edges of `oclk`, `lat` and `oe` are detected by comparing the registered value with its previous value.
  - Edges are detected on the registered samples only.
- **Shift-in**
  - Each `oclk` rise stores the registered rgb into shift slot `col_idx`, then increments `col_idx`.
  - When `col_idx` == `columns`, the sample is discarded, `overflow` pulses and `col_idx` holds.
- **Latch**
  - A `lat` rise copies all shift slots into the display register, clears `col_idx` to 0 and sets `dirty`.
  - It also records `cur_row` = registered `row_in`.
- **Display**
  - An `oe` rise adds each display-register bit (0/1) to that pixel channel's accumulator.
  - Accumulators are cyclewidth+1 bits wide and saturate at 2^cyclewidth.
- **Decode**
  - A count of 0 decodes to 0.
  - Any other count n decodes to n-1.
  - The decoded value saturates at 2^cyclewidth-1.
- **State machine**
  - CAPTURE → FLUSH when the registered `row_in` differs from `cur_row` and `dirty` = 1.
  - A row change while `dirty` = 0 only updates `cur_row`.
  - FLUSH emits columns 0..columns-1 of `cur_row`, clearing each column's accumulators when its word is accepted.
  - After the last accepted word: `row_complete` pulses, `frame_complete` also pulses if `cur_row` == rows-1, `dirty` clears, and the FSM returns to CAPTURE.
- **Activity during FLUSH**
  - Shift-in and latch continue normally.
  - An `oe` rise is dropped and `overrun` pulses.
  - A further row change during FLUSH is ignored until the FSM is back in CAPTURE.

## Timing
- **Reset state**
  - All outputs, `col_idx`, accumulators, the display register, `dirty` and `cur_row` are 0; the FSM is in CAPTURE.
  - Reset during FLUSH aborts it: `wr_valid` is 0 on the next clk and no partial row is reported.
- **Input to internal state**
  - A pad change reaches the edge detector after 1 clk.
  - The resulting action completes 1 clk later, so pin to internal state is 2 clks.
- **Flush start**
  - The row change is detected on clk t.
  - FLUSH is entered at t+1 and `wr_valid` rises at t+1.
- **Write handshake**
  - A word transfers on a clk where `wr_valid` and `wr_ready` are both 1.
  - `wr_row`, `wr_column` and `wr_pixel` are held stable while `wr_valid` = 1 and `wr_ready` = 0.
  - With `wr_ready` tied high, a flush takes `columns` clks.
  - `row_complete` pulses on the clk after the last transfer.
- **Coincident events**
  - An `oe` rise on the same clk FLUSH is entered is dropped and counted as overrun.
  - `lat` and `oclk` rises on the same clk: the latch copies the slots before the shift; the shifted bit goes to slot 0 of the new load.
- **Decoder latency**
  - The decoder is combinational from the accumulator to `wr_pixel`.

## Structure
- Package `display_pkg`:
  - FSM state encoding (CAPTURE, FLUSH).
  - Channel index constants (red=0, green=1, blue=2).
  - Pixel and rgb bit-offset functions shared with the driver side.
- Sub-module `display_count_decoder`: converts a cyclewidth+1-bit count into a cyclewidth-bit value, one instance per segment×channel.
- Input registering and edge detection stay inline.

## Test plan
- **Loopback decode:** connect `display_driver` (segments=1, cyclewidth=4) feeding constant pixel r=5, g=0, b=15 → every word has r=5, g=0, b=15.
- **Hand-driven row:** drive 32 `oclk` rises, then 16 latch+`oe` sequences with the bit set in 6 of them, then change row → the pixel decodes to 5 and `row_complete` pulses once.
- **Backpressure:** hold `wr_ready` low for 3 clks on column 7 → word 7 stays stable, all 32 columns are delivered in order and no word is duplicated.
- **Overrun:** raise `oe` during FLUSH → `overrun` pulses for 1 clk and the next row's counts exclude that period.
- **Overflow:** send 33 `oclk` rises before `lat` → `overflow` pulses once and slots 0..31 hold the first 32 samples.
- **Reset mid-flush:** assert `rst` at column 10 → `wr_valid` is 0 the next clk and all outputs return to 0.
